// File: rtl/pi1arb_pkg.sv
// Shared PI1 definitions for the single-clock round-robin arbiter.
package pi1arb_pkg;

  localparam logic [1:0] PINOOP   = 2'd0;
  localparam logic [1:0] PIWROP   = 2'd1;
  localparam logic [1:0] PIRDOP   = 2'd2;
  localparam logic [1:0] PIRDWROP = 2'd3;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++)
      if ((1 << i) < v) r = i + 1;
    return r;
  endfunction

endpackage

// File: rtl/pi1arb_rrpick.sv
// Combinational round-robin pick: first set request at or after last+1, wrapping.
module pi1arb_rrpick
  import pi1arb_pkg::*;
#(
  parameter  int N  = 2,
  localparam int GW = (N > 1) ? clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [GW-1:0] last,
  output logic          any,
  output logic [GW-1:0] idx
);

  int c;

  // Scan offsets from farthest to nearest so the nearest requester after last wins.
  always_comb begin
    any = |req;
    idx = '0;
    c   = 0;
    for (int k = N - 1; k >= 0; k--) begin
      c = (int'(last) + 1 + k) % N;
      if (req[c]) idx = GW'(c);
    end
  end

endmodule

// File: rtl/pi1arb.sv
// Shares one PI1 slave port between MASTERCOUNT masters; grant is held through a read's data phase.
module pi1arb
  import pi1arb_pkg::*;
#(
  parameter  int ARCHBITSZ   = 16,
  parameter  int MASTERCOUNT = 2,
  localparam int ADDRBITSZ   = ARCHBITSZ - clog2(ARCHBITSZ / 8),
  localparam int SELW        = ARCHBITSZ / 8,
  localparam int GW          = (MASTERCOUNT > 1) ? clog2(MASTERCOUNT) : 1
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic [2*MASTERCOUNT-1:0]       m_op_i,
  input  logic [ADDRBITSZ*MASTERCOUNT-1:0] m_addr_i,
  input  logic [ARCHBITSZ*MASTERCOUNT-1:0] m_data_i,
  input  logic [SELW*MASTERCOUNT-1:0]    m_sel_i,
  output logic [ARCHBITSZ-1:0]           m_data_o,
  output logic [MASTERCOUNT-1:0]         m_rdy_o,
  output logic [1:0]                     s_op_o,
  output logic [ADDRBITSZ-1:0]           s_addr_o,
  output logic [ARCHBITSZ-1:0]           s_data_o,
  output logic [SELW-1:0]                s_sel_o,
  input  logic [ARCHBITSZ-1:0]           s_data_i,
  input  logic                           s_rdy_i,
  output logic [GW-1:0]                  gnt_o
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_XFER   = 2'd1;
  localparam logic [1:0] ST_RDWAIT = 2'd2;

  logic [MASTERCOUNT-1:0][1:0]           op_a;
  logic [MASTERCOUNT-1:0][ADDRBITSZ-1:0] addr_a;
  logic [MASTERCOUNT-1:0][ARCHBITSZ-1:0] data_a;
  logic [MASTERCOUNT-1:0][SELW-1:0]      sel_a;
  logic [MASTERCOUNT-1:0]                req;

  logic [1:0]    state;
  logic [GW-1:0] gnt, last, pick_idx;
  logic          pick_any;
  logic [1:0]    cur_op;

  assign op_a   = m_op_i;
  assign addr_a = m_addr_i;
  assign data_a = m_data_i;
  assign sel_a  = m_sel_i;

  genvar gi;
  generate
    for (gi = 0; gi < MASTERCOUNT; gi++) begin : g_req
      assign req[gi] = (op_a[gi] != PINOOP);
    end
  endgenerate

  pi1arb_rrpick #(.N(MASTERCOUNT)) u_pick (
    .req  (req),
    .last (last),
    .any  (pick_any),
    .idx  (pick_idx)
  );

  assign cur_op   = op_a[gnt];
  assign m_data_o = s_data_i;
  assign gnt_o    = gnt;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state <= ST_IDLE;
      gnt   <= '0;
      last  <= GW'(MASTERCOUNT - 1);
    end else begin
      case (state)
        ST_IDLE: begin
          if (pick_any) begin
            gnt   <= pick_idx;
            state <= ST_XFER;
          end
        end
        ST_XFER: begin
          // A master withdrawing its op before accept forfeits the slot without rotating.
          if (cur_op == PINOOP) begin
            state <= ST_IDLE;
          end else if (s_rdy_i) begin
            if (cur_op == PIWROP) begin
              last  <= gnt;
              state <= ST_IDLE;
            end else begin
              state <= ST_RDWAIT;
            end
          end
        end
        ST_RDWAIT: begin
          if (s_rdy_i) begin
            last  <= gnt;
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  always_comb begin
    s_op_o   = PINOOP;
    s_addr_o = '0;
    s_data_o = '0;
    s_sel_o  = '0;
    m_rdy_o  = '0;
    case (state)
      ST_XFER: begin
        s_op_o        = cur_op;
        s_addr_o      = addr_a[gnt];
        s_data_o      = data_a[gnt];
        s_sel_o       = sel_a[gnt];
        m_rdy_o[gnt]  = s_rdy_i;
      end
      ST_RDWAIT: m_rdy_o[gnt] = s_rdy_i;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_pi1arb.sv
// Directed self-checking bench for pi1arb (2-master and 4-master instances).
module tb_pi1arb;
  import pi1arb_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // 2-master instance
  logic [1:0][1:0]  op2;
  logic [1:0][14:0] addr2;
  logic [1:0][15:0] data2;
  logic [1:0][1:0]  sel2;
  logic [15:0] m_data2, s_data_o2, s_data_i2;
  logic [1:0]  m_rdy2, s_op2, s_sel2;
  logic [14:0] s_addr2;
  logic        s_rdy2;
  logic        gnt2;

  // 4-master instance
  logic [3:0][1:0]  op4;
  logic [3:0][14:0] addr4;
  logic [3:0][15:0] data4;
  logic [3:0][1:0]  sel4;
  logic [15:0] m_data4, s_data_o4, s_data_i4;
  logic [3:0]  m_rdy4;
  logic [1:0]  s_op4, s_sel4, gnt4;
  logic [14:0] s_addr4;
  logic        s_rdy4;

  int checks = 0;
  int failures = 0;

  pi1arb #(.ARCHBITSZ(16), .MASTERCOUNT(2)) u2 (
    .clk_i(clk), .rst_i(rst), .m_op_i(op2), .m_addr_i(addr2), .m_data_i(data2),
    .m_sel_i(sel2), .m_data_o(m_data2), .m_rdy_o(m_rdy2), .s_op_o(s_op2),
    .s_addr_o(s_addr2), .s_data_o(s_data_o2), .s_sel_o(s_sel2),
    .s_data_i(s_data_i2), .s_rdy_i(s_rdy2), .gnt_o(gnt2)
  );

  pi1arb #(.ARCHBITSZ(16), .MASTERCOUNT(4)) u4 (
    .clk_i(clk), .rst_i(rst), .m_op_i(op4), .m_addr_i(addr4), .m_data_i(data4),
    .m_sel_i(sel4), .m_data_o(m_data4), .m_rdy_o(m_rdy4), .s_op_o(s_op4),
    .s_addr_o(s_addr4), .s_data_o(s_data_o4), .s_sel_o(s_sel4),
    .s_data_i(s_data_i4), .s_rdy_i(s_rdy4), .gnt_o(gnt4)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  int cnt0, cnt1, n;
  int order[4];
  logic [3:0] done4;

  initial begin
    rst = 1'b1;
    op2 = '0; addr2 = '0; data2 = '0; sel2 = '0; s_data_i2 = '0; s_rdy2 = 1'b0;
    op4 = '0; addr4 = '0; data4 = '0; sel4 = '0; s_data_i4 = '0; s_rdy4 = 1'b1;
    order[0] = 3; order[1] = 0; order[2] = 1; order[3] = 2;
    tick();
    tick();
    rst = 1'b0;

    // Reset then idle
    for (int i = 0; i < 10; i++) begin
      #1;
      chk("idle_sop", s_op2, 0);
      chk("idle_rdy", m_rdy2, 0);
      chk("idle_gnt", gnt2, 0);
      tick();
    end

    // Single write from m0
    op2[0] = PIWROP; addr2[0] = 15'h12; data2[0] = 16'hBEEF; sel2[0] = 2'b11; s_rdy2 = 1'b1;
    #1;
    chk("wr_arb_sop", s_op2, 0);
    chk("wr_arb_rdy", m_rdy2, 0);
    tick();
    chk("wr_sop", s_op2, 1);
    chk("wr_addr", s_addr2, 15'h12);
    chk("wr_data", s_data_o2, 16'hBEEF);
    chk("wr_sel", s_sel2, 2'b11);
    chk("wr_rdy", m_rdy2, 2'b01);
    chk("wr_gnt", gnt2, 0);
    tick();
    op2[0] = PINOOP;
    #1;
    chk("wr_done_sop", s_op2, 0);
    chk("wr_done_rdy", m_rdy2, 0);
    chk("wr_done_addr", s_addr2, 0);

    // Single read from m1 with 3-cycle data stall
    op2[1] = PIRDOP; addr2[1] = 15'h40;
    tick();
    chk("rd_sop", s_op2, 2);
    chk("rd_addr", s_addr2, 15'h40);
    chk("rd_rdy", m_rdy2, 2'b10);
    chk("rd_gnt", gnt2, 1);
    tick();
    op2[1] = PINOOP; s_rdy2 = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("rd_stall_rdy", m_rdy2, 0);
      chk("rd_stall_sop", s_op2, 0);
      tick();
    end
    s_rdy2 = 1'b1; s_data_i2 = 16'h1234;
    #1;
    chk("rd_data_rdy", m_rdy2, 2'b10);
    chk("rd_data", m_data2, 16'h1234);
    tick();
    s_data_i2 = '0;

    // Contention: 4 writes each, grants must alternate starting with m0
    cnt0 = 0; cnt1 = 0; n = 0;
    for (int cyc = 0; cyc < 40; cyc++) begin
      op2[0] = (cnt0 < 4) ? PIWROP : PINOOP;
      op2[1] = (cnt1 < 4) ? PIWROP : PINOOP;
      data2[0] = 16'(16'hA000 + cnt0);
      data2[1] = 16'(16'hB000 + cnt1);
      #1;
      if (m_rdy2 != 2'b00) begin
        chk("cont_rdy", m_rdy2, 2'b01 << (n % 2));
        chk("cont_gnt", gnt2, n % 2);
        if (m_rdy2[0]) cnt0++;
        if (m_rdy2[1]) cnt1++;
        n++;
      end
      tick();
    end
    chk("cont_cnt0", cnt0, 4);
    chk("cont_cnt1", cnt1, 4);
    op2 = '0;

    // Reset mid-read: first make last=0 with an m0 write, then m1 reads
    op2[0] = PIWROP; s_rdy2 = 1'b1;
    tick();
    tick();
    op2[0] = PINOOP;
    op2[1] = PIRDOP; addr2[1] = 15'h55;
    tick();
    chk("rst_rd_gnt", gnt2, 1);
    tick();
    op2[1] = PINOOP; s_rdy2 = 1'b0;
    #1;
    chk("rst_rdwait_rdy", m_rdy2, 0);
    rst = 1'b1;
    tick();
    s_rdy2 = 1'b1;
    #1;
    chk("rst_sop", s_op2, 0);
    chk("rst_rdy", m_rdy2, 0);
    chk("rst_gnt", gnt2, 0);
    rst = 1'b0;
    op2[0] = PIWROP; op2[1] = PIWROP;
    tick();
    chk("post_rst_gnt", gnt2, 0);
    chk("post_rst_rdy", m_rdy2, 2'b01);
    tick();
    op2 = '0;

    // 4 masters: make last=2 via an m2 write, then all request -> 3,0,1,2
    op4[2] = PIWROP;
    tick();
    chk("mc4_pre_gnt", gnt4, 2);
    tick();
    done4 = '0; n = 0;
    for (int cyc = 0; cyc < 30; cyc++) begin
      for (int i = 0; i < 4; i++) op4[i] = done4[i] ? PINOOP : PIWROP;
      #1;
      if (m_rdy4 != 4'b0000) begin
        if (n < 4) begin
          chk("mc4_rdy", m_rdy4, 4'b0001 << order[n]);
          chk("mc4_gnt", gnt4, order[n]);
        end
        done4 = done4 | m_rdy4;
        n++;
      end
      tick();
    end
    chk("mc4_count", n, 4);
    op4 = '0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
